// File: rtl/multicycle_alu.sv
// Execute-stage ALU with registered results, valid/ready on both sides and iterative mul/div.
// Define ALU_MULDIV_EN to build the shift-add multiplier and restoring divider (MUL/DIV states).
module multicycle_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] operandA,
    input  logic [DATA_WIDTH-1:0] operandB,
    input  logic [3:0]            aluOp,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zeroFlag,
    output logic                  carryFlag,
    output logic                  overflowFlag,
    output logic                  divZeroFlag,
    output logic                  illegalOpFlag,
    output logic                  busy
);
    localparam int DW = DATA_WIDTH;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam int         CNT_W    = $clog2(DW);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`endif

    state_t          state_q;
    logic [DW-1:0]   result_q;
    logic            zero_q, carry_q, ovf_q, dz_q, ill_q;

    logic            accept;
    logic [DW:0]     add_full;
    logic [DW-1:0]   sub_res;
    logic signed [DW-1:0] sra_res;
    logic [SHAMT_W-1:0]   shamt;
    logic [DW-1:0]   sc_res;
    logic            sc_carry, sc_ovf, sc_dz, sc_ill;

    assign inReady  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && outReady);
    assign accept   = inValid && inReady;
    assign outValid = (state_q == ST_DONE);

    assign add_full = {1'b0, operandA} + {1'b0, operandB};
    assign sub_res  = operandA - operandB;
    assign shamt    = operandB[SHAMT_W-1:0];
    assign sra_res  = $signed(operandA) >>> shamt;

    // Ops that finish on the accept edge, including divide-by-zero which needs no iteration.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        sc_ill   = 1'b0;
        case (aluOp)
            OP_ADD: begin
                sc_res   = add_full[DW-1:0];
                sc_carry = add_full[DW];
                sc_ovf   = (operandA[DW-1] == operandB[DW-1]) && (add_full[DW-1] != operandA[DW-1]);
            end
            OP_SUB: begin
                sc_res   = sub_res;
                sc_carry = operandA < operandB;
                sc_ovf   = (operandA[DW-1] != operandB[DW-1]) && (sub_res[DW-1] != operandA[DW-1]);
            end
            OP_AND: sc_res = operandA & operandB;
            OP_OR:  sc_res = operandA | operandB;
            OP_XOR: sc_res = operandA ^ operandB;
            OP_SLT: sc_res = {{(DW-1){1'b0}}, $signed(operandA) < $signed(operandB)};
            OP_SLL: sc_res = operandA << shamt;
            OP_SRL: sc_res = operandA >> shamt;
            OP_SRA: sc_res = sra_res;
`ifdef ALU_MULDIV_EN
            OP_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_REMU: begin
                sc_res = operandA;
                sc_dz  = 1'b1;
            end
`endif
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // acc_q holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
    logic [2*DW-1:0] acc_q;
    logic [DW-1:0]   opnd_q;
    logic            hi_sel_q;
    logic [CNT_W-1:0] cnt_q;

    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_acc_d;
    logic [DW:0]     rem_shift;
    logic [DW:0]     trial;
    logic [2*DW-1:0] div_acc_d;
    logic [DW-1:0]   mul_res, div_res;
    logic            is_mul, is_div, last_iter;

    assign mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_d = {mul_sum, acc_q[DW-1:1]};
    assign rem_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    assign trial     = rem_shift - {1'b0, opnd_q};
    assign div_acc_d = trial[DW] ? {rem_shift[DW-1:0], acc_q[DW-2:0], 1'b0}
                                 : {trial[DW-1:0],     acc_q[DW-2:0], 1'b1};
    assign mul_res   = hi_sel_q ? mul_acc_d[2*DW-1:DW] : mul_acc_d[DW-1:0];
    assign div_res   = hi_sel_q ? div_acc_d[2*DW-1:DW] : div_acc_d[DW-1:0];
    assign is_mul    = (aluOp == OP_MUL) || (aluOp == OP_MULHU);
    assign is_div    = (aluOp == OP_DIVU) || (aluOp == OP_REMU);
    assign last_iter = (cnt_q == CNT_W'(DW - 1));
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
`else
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_sel_q <= 1'b0;
            cnt_q    <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_MULDIV_EN
            if (is_mul) begin
                state_q  <= ST_MUL;
                acc_q    <= {{DW{1'b0}}, operandB};
                opnd_q   <= operandA;
                hi_sel_q <= (aluOp == OP_MULHU);
                cnt_q    <= '0;
            end else if (is_div && (operandB != '0)) begin
                state_q  <= ST_DIV;
                acc_q    <= {{DW{1'b0}}, operandA};
                opnd_q   <= operandB;
                hi_sel_q <= (aluOp == OP_REMU);
                cnt_q    <= '0;
            end else
`endif
            begin
                state_q  <= ST_DONE;
                result_q <= sc_res;
                zero_q   <= (sc_res == '0);
                carry_q  <= sc_carry;
                ovf_q    <= sc_ovf;
                dz_q     <= sc_dz;
                ill_q    <= sc_ill;
            end
        end else begin
            case (state_q)
`ifdef ALU_MULDIV_EN
                ST_MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q  <= ST_DONE;
                        result_q <= mul_res;
                        zero_q   <= (mul_res == '0);
                        carry_q  <= 1'b0;
                        ovf_q    <= !hi_sel_q && (mul_acc_d[2*DW-1:DW] != '0);
                        dz_q     <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
                ST_DIV: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q  <= ST_DONE;
                        result_q <= div_res;
                        zero_q   <= (div_res == '0);
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        dz_q     <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
`endif
                ST_DONE: if (outReady) state_q <= ST_IDLE;
                default: ;
            endcase
        end
    end

    assign result        = result_q;
    assign zeroFlag      = zero_q;
    assign carryFlag     = carry_q;
    assign overflowFlag  = ovf_q;
    assign divZeroFlag   = dz_q;
    assign illegalOpFlag = ill_q;
endmodule
